// File: rtl/tlb_pkg.sv
// tlb_pkg: shared types and widths for the TLB maintenance-op sequencer
package tlb_pkg;
  localparam int TLBNUM_DEF = 16;
  localparam int IDX_W_DEF  = 4;
  localparam int VPN2_W     = 19;
  localparam int ASID_W     = 8;
  typedef enum logic [2:0] {
    S_IDLE, S_SEARCH, S_READ, S_WRITE, S_COMMIT, S_REFETCH
  } state_e;
  typedef enum logic [1:0] {OP_TLBP, OP_TLBR, OP_TLBWI, OP_TLBWR} op_e;
endpackage

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: MEM-stage sequencer for tlbp/tlbr/tlbwi/tlbwr.
// Ports: clk/reset (sync, active-high); ms_* MEM-stage op, pc, exception and
// eret flush; cp0_* Index/Random/EntryHi; s1_* TLB search port; r_index TLB
// read port; we/w_index TLB write port; inst_tlbp/inst_tlbr CP0 strobes;
// tlb_to_cp0_* registered tlbp result; ms_stall pipeline hold;
// refetch_flush/refetch_pc restart after the op.
// Build option: define TLB_REFETCH_EN to add the REFETCH state; without it
// COMMIT returns to IDLE and refetch_flush/refetch_pc are tied 0.
module tlb_op_ctrl import tlb_pkg::*; #(
  parameter int TLBNUM = TLBNUM_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ms_valid,
  input  logic              ms_ex,
  input  logic              eret_flush,
  input  logic              ms_inst_tlbp,
  input  logic              ms_inst_tlbr,
  input  logic              ms_inst_tlbwi,
  input  logic              ms_inst_tlbwr,
  input  logic [31:0]       ms_pc,
  input  logic [IDX_W-1:0]  cp0_index,
  input  logic [IDX_W-1:0]  cp0_random,
  input  logic [18:0]       cp0_vpn2,
  input  logic [7:0]        cp0_asid,
  output logic [18:0]       s1_vpn2,
  output logic [7:0]        s1_asid,
  input  logic              s1_found,
  input  logic [IDX_W-1:0]  s1_index,
  output logic [IDX_W-1:0]  r_index,
  output logic              we,
  output logic [IDX_W-1:0]  w_index,
  output logic              inst_tlbp,
  output logic              inst_tlbr,
  output logic              tlb_to_cp0_found,
  output logic [IDX_W-1:0]  tlb_to_cp0_index,
  output logic              ms_stall,
  output logic              refetch_flush,
  output logic [31:0]       refetch_pc
);
  state_e             state_q, state_d;
  op_e                op_q, op_d, op_sel;
  logic [IDX_W-1:0]   idx_q, idx_d, fidx_q, fidx_d;
  logic               found_q, found_d, accept, start, run;
`ifdef TLB_REFETCH_EN
  logic [31:0]        pc_q, pc_d;
`else
  logic               unused_pc;
  assign unused_pc = ^ms_pc;
`endif
  always_comb begin
    accept  = ms_valid && !ms_ex && !eret_flush &&
              (ms_inst_tlbp || ms_inst_tlbr || ms_inst_tlbwi || ms_inst_tlbwr);
    op_sel  = ms_inst_tlbp ? OP_TLBP : ms_inst_tlbr ? OP_TLBR :
              ms_inst_tlbwi ? OP_TLBWI : OP_TLBWR;
    start   = state_q == S_IDLE && accept;
    state_d = state_q;
    case (state_q)
      S_IDLE:                    state_d = !accept ? S_IDLE :
                                           op_sel == OP_TLBP ? S_SEARCH :
                                           op_sel == OP_TLBR ? S_READ : S_WRITE;
      S_SEARCH, S_READ, S_WRITE: state_d = S_COMMIT;
`ifdef TLB_REFETCH_EN
      S_COMMIT:                  state_d = S_REFETCH;
`else
      S_COMMIT:                  state_d = S_IDLE;
`endif
      default:                   state_d = S_IDLE;
    endcase
    op_d    = start ? op_sel : op_q;
    idx_d   = start ? (op_sel == OP_TLBWR ? cp0_random : cp0_index) : idx_q;
    found_d = state_q == S_SEARCH ? s1_found : found_q;
    fidx_d  = state_q == S_SEARCH ? s1_index : fidx_q;
`ifdef TLB_REFETCH_EN
    pc_d    = start ? ms_pc + 32'd4 : pc_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_TLBP;
      idx_q   <= '0;
      found_q <= 1'b0;
      fidx_q  <= '0;
`ifdef TLB_REFETCH_EN
      pc_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      found_q <= found_d;
      fidx_q  <= fidx_d;
`ifdef TLB_REFETCH_EN
      pc_q    <= pc_d;
`endif
    end
  end
  // Outputs decode the state register but are forced low during reset so a
  // reset landing mid-op never issues a write or a CP0 strobe.
  assign run              = !reset;
  assign s1_vpn2          = run && state_q == S_SEARCH ? cp0_vpn2 : '0;
  assign s1_asid          = run && state_q == S_SEARCH ? cp0_asid : '0;
  // Read index stays up through COMMIT so the TLB read data is valid at the strobe.
  assign r_index          = run && (state_q == S_READ ||
                            (state_q == S_COMMIT && op_q == OP_TLBR)) ? idx_q : '0;
  assign we               = run && state_q == S_WRITE && int'(idx_q) < TLBNUM;
  assign w_index          = run && state_q == S_WRITE ? idx_q : '0;
  assign inst_tlbp        = run && state_q == S_COMMIT && op_q == OP_TLBP;
  assign inst_tlbr        = run && state_q == S_COMMIT && op_q == OP_TLBR;
  assign tlb_to_cp0_found = found_q;
  assign tlb_to_cp0_index = fidx_q;
  assign ms_stall         = run && (state_q == S_IDLE ? accept : state_q != S_REFETCH);
`ifdef TLB_REFETCH_EN
  assign refetch_flush    = run && state_q == S_REFETCH;
  assign refetch_pc       = refetch_flush ? pc_q : '0;
`else
  assign refetch_flush    = 1'b0;
  assign refetch_pc       = '0;
`endif
endmodule
